// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and memory command/response signals
// shared between the pipeline side (master) and the arbiter (slave).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              stall_if;
  logic              stall_mem;

  logic              mem_en;
  logic              mem_wre;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           stall_if, stall_mem, mem_en, mem_wre, mem_addr, mem_wdata
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           stall_if, stall_mem, mem_en, mem_wre, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between fetch (I) and data (D)
// requesters: data-priority grant with a starvation bound for fetch.
module mem_port_arbiter #(
  parameter int ADDR_W       = 7,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 2
) (
  input  logic                clock,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic              iGnt;
  logic              dGnt;
  logic              iStarveWin;

  logic [3:0]        starveCnt_q,  starveCnt_d;
  logic              memEn_q,      memEn_d;
  logic              memWre_q,     memWre_d;
  logic [ADDR_W-1:0] memAddr_q,    memAddr_d;
  logic [DATA_W-1:0] memWdata_q,   memWdata_d;
  logic              tag0Valid_q,  tag0Valid_d;
  logic              tag0OwnerD_q, tag0OwnerD_d;
  logic              tag1Valid_q,  tag1Valid_d;
  logic              tag1OwnerD_q, tag1OwnerD_d;
  logic              iRvalid_q,    iRvalid_d;
  logic              dRvalid_q,    dRvalid_d;
  logic [DATA_W-1:0] iRdata_q,     iRdata_d;
  logic [DATA_W-1:0] dRdata_q,     dRdata_d;

  // Fetch overrides data only once it has lost STARVE_LIMIT cycles in a row.
  always_comb begin
    iStarveWin = bus.i_req && (starveCnt_q == LIMIT);
    dGnt       = bus.d_req && !iStarveWin;
    iGnt       = bus.i_req && !dGnt;
  end

  always_comb begin
    starveCnt_d  = starveCnt_q;
    memEn_d      = 1'b0;
    memWre_d     = 1'b0;
    memAddr_d    = memAddr_q;
    memWdata_d   = memWdata_q;
    tag0Valid_d  = 1'b0;
    tag0OwnerD_d = 1'b0;
    tag1Valid_d  = tag0Valid_q;
    tag1OwnerD_d = tag0OwnerD_q;
    iRvalid_d    = 1'b0;
    dRvalid_d    = 1'b0;
    iRdata_d     = iRdata_q;
    dRdata_d     = dRdata_q;

    if (!bus.i_req || iGnt) begin
      starveCnt_d = 4'd0;
    end else if (dGnt && (starveCnt_q < LIMIT)) begin
      starveCnt_d = starveCnt_q + 4'd1;
    end

    if (dGnt) begin
      memEn_d      = 1'b1;
      memWre_d     = bus.d_we;
      memAddr_d    = bus.d_addr;
      memWdata_d   = bus.d_wdata;
      tag0Valid_d  = !bus.d_we;
      tag0OwnerD_d = 1'b1;
    end else if (iGnt) begin
      memEn_d      = 1'b1;
      memAddr_d    = bus.i_addr;
      memWdata_d   = '0;
      tag0Valid_d  = 1'b1;
    end

    // Stage 1 marks the cycle where the memory output belongs to this read.
    if (tag1Valid_q) begin
      if (tag1OwnerD_q) begin
        dRvalid_d = 1'b1;
        dRdata_d  = bus.mem_rdata;
      end else begin
        iRvalid_d = 1'b1;
        iRdata_d  = bus.mem_rdata;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starveCnt_q  <= 4'd0;
      memEn_q      <= 1'b0;
      memWre_q     <= 1'b0;
      memAddr_q    <= '0;
      memWdata_q   <= '0;
      tag0Valid_q  <= 1'b0;
      tag0OwnerD_q <= 1'b0;
      tag1Valid_q  <= 1'b0;
      tag1OwnerD_q <= 1'b0;
      iRvalid_q    <= 1'b0;
      dRvalid_q    <= 1'b0;
      iRdata_q     <= '0;
      dRdata_q     <= '0;
    end else begin
      starveCnt_q  <= starveCnt_d;
      memEn_q      <= memEn_d;
      memWre_q     <= memWre_d;
      memAddr_q    <= memAddr_d;
      memWdata_q   <= memWdata_d;
      tag0Valid_q  <= tag0Valid_d;
      tag0OwnerD_q <= tag0OwnerD_d;
      tag1Valid_q  <= tag1Valid_d;
      tag1OwnerD_q <= tag1OwnerD_d;
      iRvalid_q    <= iRvalid_d;
      dRvalid_q    <= dRvalid_d;
      iRdata_q     <= iRdata_d;
      dRdata_q     <= dRdata_d;
    end
  end

  assign bus.i_gnt     = iGnt;
  assign bus.d_gnt     = dGnt;
  assign bus.stall_if  = bus.i_req && !iGnt;
  assign bus.stall_mem = bus.d_req && !dGnt;
  assign bus.mem_en    = memEn_q;
  assign bus.mem_wre   = memWre_q;
  assign bus.mem_addr  = memAddr_q;
  assign bus.mem_wdata = memWdata_q;
  assign bus.i_rvalid  = iRvalid_q;
  assign bus.i_rdata   = iRdata_q;
  assign bus.d_rvalid  = dRvalid_q;
  assign bus.d_rdata   = dRdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 128x32 synchronous
// memory whose word k initially holds the value k.
module tb_mem_port_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  mem_port_arbiter_if #(.ADDR_W(7), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(7), .DATA_W(32), .STARVE_LIMIT(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [31:0] mem [128];
  logic [31:0] memRdata = '0;
  bit          memReady = 1'b0;

  // Memory model is the only writer of its array; it fills itself on the first edge.
  always @(posedge clock) begin
    if (!memReady) begin
      for (int k = 0; k < 128; k++) mem[k] <= 32'(k);
      memReady <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_wre) mem[bus.mem_addr] <= bus.mem_wdata;
      else             memRdata <= mem[bus.mem_addr];
    end
  end

  assign bus.mem_rdata = memRdata;

  task automatic applyStimulus(input logic iReq, input logic [6:0] iAddr,
                               input logic dReq, input logic dWe,
                               input logic [6:0] dAddr, input logic [31:0] dWdata);
    bus.i_req   = iReq;
    bus.i_addr  = iAddr;
    bus.d_req   = dReq;
    bus.d_we    = dWe;
    bus.d_addr  = dAddr;
    bus.d_wdata = dWdata;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    bit expD6 [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    bit expD3 [3] = '{1'b1, 1'b1, 1'b0};

    applyStimulus(0, 0, 0, 0, 0, 0);
    #10;
    checkOutput("rst_i_rvalid", 32'(bus.i_rvalid), 0);
    checkOutput("rst_d_rvalid", 32'(bus.d_rvalid), 0);
    checkOutput("rst_mem_en", 32'(bus.mem_en), 0);
    checkOutput("rst_mem_wre", 32'(bus.mem_wre), 0);
    checkOutput("rst_mem_addr", 32'(bus.mem_addr), 0);
    checkOutput("rst_mem_wdata", bus.mem_wdata, 0);
    checkOutput("rst_i_rdata", bus.i_rdata, 0);
    checkOutput("rst_d_rdata", bus.d_rdata, 0);
    @(negedge clock);
    reset = 1'b1;
    nextCycle();

    // Single fetch of word 5
    applyStimulus(1, 5, 0, 0, 0, 0);
    checkOutput("sf_i_gnt", 32'(bus.i_gnt), 1);
    checkOutput("sf_d_gnt", 32'(bus.d_gnt), 0);
    checkOutput("sf_stall_if", 32'(bus.stall_if), 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("sf_mem_en", 32'(bus.mem_en), 1);
    checkOutput("sf_mem_addr", 32'(bus.mem_addr), 5);
    checkOutput("sf_mem_wre", 32'(bus.mem_wre), 0);
    checkOutput("sf_i_rvalid_e0", 32'(bus.i_rvalid), 0);
    nextCycle();
    checkOutput("sf_i_rvalid_e1", 32'(bus.i_rvalid), 0);
    checkOutput("sf_mem_en_off", 32'(bus.mem_en), 0);
    nextCycle();
    checkOutput("sf_i_rvalid_e2", 32'(bus.i_rvalid), 1);
    checkOutput("sf_i_rdata", bus.i_rdata, 32'h5);
    checkOutput("sf_d_rvalid", 32'(bus.d_rvalid), 0);
    nextCycle();
    checkOutput("sf_i_rvalid_e3", 32'(bus.i_rvalid), 0);
    checkOutput("sf_i_rdata_hold", bus.i_rdata, 32'h5);

    // Data write to 12 followed by read of 12
    applyStimulus(0, 0, 1, 1, 12, 32'hAE08000C);
    checkOutput("wr_d_gnt", 32'(bus.d_gnt), 1);
    checkOutput("wr_i_gnt", 32'(bus.i_gnt), 0);
    nextCycle();
    applyStimulus(0, 0, 1, 0, 12, 0);
    checkOutput("rd_d_gnt", 32'(bus.d_gnt), 1);
    checkOutput("wr_mem_en", 32'(bus.mem_en), 1);
    checkOutput("wr_mem_wre", 32'(bus.mem_wre), 1);
    checkOutput("wr_mem_addr", 32'(bus.mem_addr), 12);
    checkOutput("wr_mem_wdata", bus.mem_wdata, 32'hAE08000C);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("rd_mem_en", 32'(bus.mem_en), 1);
    checkOutput("rd_mem_wre", 32'(bus.mem_wre), 0);
    checkOutput("rd_d_rvalid_a", 32'(bus.d_rvalid), 0);
    nextCycle();
    checkOutput("wr_no_rvalid", 32'(bus.d_rvalid), 0);
    nextCycle();
    checkOutput("rd_d_rvalid", 32'(bus.d_rvalid), 1);
    checkOutput("rd_d_rdata", bus.d_rdata, 32'hAE08000C);
    nextCycle();
    checkOutput("rd_d_rvalid_end", 32'(bus.d_rvalid), 0);

    // Contention with starvation bound
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 1, 1, 0, 2, 0);
      checkOutput($sformatf("ct_d_gnt_%0d", i), 32'(bus.d_gnt), 32'(expD6[i]));
      checkOutput($sformatf("ct_i_gnt_%0d", i), 32'(bus.i_gnt), 32'(!expD6[i]));
      checkOutput($sformatf("ct_stall_if_%0d", i), 32'(bus.stall_if), 32'(expD6[i]));
      checkOutput($sformatf("ct_stall_mem_%0d", i), 32'(bus.stall_mem), 32'(!expD6[i]));
      nextCycle();
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) nextCycle();

    // Interleaved reads D@3, I@7, D@9
    applyStimulus(0, 0, 1, 0, 3, 0);
    nextCycle();
    applyStimulus(1, 7, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 1, 0, 9, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("il_d_rvalid_1", 32'(bus.d_rvalid), 1);
    checkOutput("il_d_rdata_1", bus.d_rdata, 3);
    checkOutput("il_i_rvalid_1", 32'(bus.i_rvalid), 0);
    nextCycle();
    checkOutput("il_i_rvalid_2", 32'(bus.i_rvalid), 1);
    checkOutput("il_i_rdata_2", bus.i_rdata, 7);
    checkOutput("il_d_rvalid_2", 32'(bus.d_rvalid), 0);
    nextCycle();
    checkOutput("il_d_rvalid_3", 32'(bus.d_rvalid), 1);
    checkOutput("il_d_rdata_3", bus.d_rdata, 9);
    checkOutput("il_i_rvalid_3", 32'(bus.i_rvalid), 0);
    nextCycle();
    checkOutput("il_d_rvalid_4", 32'(bus.d_rvalid), 0);
    checkOutput("il_i_rvalid_4", 32'(bus.i_rvalid), 0);

    // Reset one cycle after a read accept
    applyStimulus(1, 6, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    checkOutput("mr_mem_en", 32'(bus.mem_en), 0);
    checkOutput("mr_mem_addr", 32'(bus.mem_addr), 0);
    checkOutput("mr_i_rdata", bus.i_rdata, 0);
    checkOutput("mr_d_rdata", bus.d_rdata, 0);
    applyStimulus(0, 0, 1, 0, 4, 0);
    checkOutput("mr_d_gnt_in_reset", 32'(bus.d_gnt), 1);
    checkOutput("mr_stall_mem", 32'(bus.stall_mem), 0);
    nextCycle();
    checkOutput("mr_no_accept", 32'(bus.mem_en), 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    nextCycle();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      checkOutput($sformatf("mr_i_rvalid_%0d", i), 32'(bus.i_rvalid), 0);
      checkOutput($sformatf("mr_d_rvalid_%0d", i), 32'(bus.d_rvalid), 0);
    end
    applyStimulus(1, 5, 0, 0, 0, 0);
    checkOutput("pr_i_gnt", 32'(bus.i_gnt), 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("pr_mem_en", 32'(bus.mem_en), 1);
    checkOutput("pr_mem_addr", 32'(bus.mem_addr), 5);
    nextCycle();
    nextCycle();
    checkOutput("pr_i_rvalid", 32'(bus.i_rvalid), 1);
    checkOutput("pr_i_rdata", bus.i_rdata, 5);
    nextCycle();

    // Idle run, then contention shows the starve counter started at zero
    for (int i = 0; i < 10; i++) begin
      nextCycle();
      checkOutput($sformatf("id_mem_en_%0d", i), 32'(bus.mem_en), 0);
      checkOutput($sformatf("id_mem_wre_%0d", i), 32'(bus.mem_wre), 0);
      checkOutput($sformatf("id_rvalid_%0d", i), 32'(bus.i_rvalid | bus.d_rvalid), 0);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 1, 0, 2, 0);
      checkOutput($sformatf("ic_d_gnt_%0d", i), 32'(bus.d_gnt), 32'(expD3[i]));
      checkOutput($sformatf("ic_i_gnt_%0d", i), 32'(bus.i_gnt), 32'(!expD3[i]));
      nextCycle();
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) nextCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter that shares one single-port 128 x 32 memory between the instruction-fetch requester (I) and the MEM-stage data requester (D) of the pipeline. It picks one request per cycle, registers the chosen command toward the memory, and routes the read data back to the owning requester. It also drives the stall signals that freeze the losing stage. Data has priority, and a starvation counter bounds how long fetch can wait.

## Interface
- ADDR_W, 7, word-address width
- DATA_W, 32, data width
- STARVE_LIMIT, 2, consecutive lost cycles after which I wins once (range 1..15)

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- i_req  in  1  fetch read request, held until accepted
- i_addr  in  ADDR_W  fetch word address
- i_gnt  out  1  combinational; I request is accepted at this rising edge
- i_rvalid  out  1  registered one-cycle pulse: i_rdata valid
- i_rdata  out  DATA_W  registered fetch read data
- d_req  in  1  data request, held until accepted
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  write data
- d_gnt  out  1  combinational; D request is accepted at this rising edge
- d_rvalid  out  1  registered one-cycle pulse: d_rdata valid (reads only)
- d_rdata  out  DATA_W  registered data read value
- stall_if  out  1  i_req & ~i_gnt
- stall_mem  out  1  d_req & ~d_gnt
- mem_en  out  1  registered; memory performs the command at the next edge
- mem_wre  out  1  registered; 1 = write
- mem_addr  out  ADDR_W  registered
- mem_wdata  out  DATA_W  registered
- mem_rdata  in  DATA_W  synchronous-read output; valid the cycle after the memory edge that read it

## Operation
- Grant logic is combinational from the requests and the registered starve_cnt:
  - When starve_cnt == STARVE_LIMIT and i_req = 1, I wins.
  - Otherwise, when d_req = 1, D wins.
  - Otherwise, when i_req = 1, I wins.
  - At most one gnt is high in any cycle.
- starve_cnt (4 bits):
  - Increments when i_req & d_gnt.
  - Clears when i_gnt = 1 or i_req = 0.
  - Saturates at STARVE_LIMIT.
- Accept edge (req & gnt): mem_en <= 1, and mem_addr, mem_wre and mem_wdata are loaded from the winner. I always drives mem_wre = 0 and mem_wdata = 0.
- No accept: mem_en <= 0, mem_wre <= 0, and mem_addr/mem_wdata hold their values.
- Read tracking is a 2-stage tag pipe of {valid, owner}:
  - Stage 0 is loaded at the accept edge for reads only.
  - Stage 0 shifts to stage 1 at the next edge, which is the memory edge.
  - When stage 1 is valid, the next edge captures mem_rdata into the owner's rdata and pulses that owner's rvalid for one cycle.
- Writes produce no rvalid.
- Back-to-back accepts are allowed every cycle, with any mix of owners. Responses return in issue order.
- The rdata registers hold their value between pulses.

## Timing
- Throughput: 1 command per cycle.
- Read latency: accept at edge E0, mem_en high during E0–E1, memory reads at E1, capture at E2. rvalid is high E2–E3, i.e. 2 cycles after accept.
- Write: accept at E0, memory written at E1.
- A read of the same address accepted the cycle after a write returns the new data, because the memory performs commands in order.
- Simultaneous i_req and d_req: D wins unless starve_cnt == STARVE_LIMIT.
- Reset values, all asserted asynchronously:
  - i_rvalid, d_rvalid, mem_en, mem_wre = 0
  - i_rdata, d_rdata, mem_addr, mem_wdata = 0
  - starve_cnt = 0; both tag stages invalid.
- Reset mid-operation: all in-flight reads are discarded, and no rvalid pulses after reset is released.
- Reset low: gnt outputs still follow the combinational rule, but no accepts take effect. stall_if and stall_mem follow their equations.

## Test plan
- Single fetch: i_req = 1, i_addr = 5, memory holds word 5 = 0x00000005 → i_gnt same cycle; mem_en/mem_addr = 5 next cycle; i_rvalid pulse with i_rdata = 0x5 two cycles after accept; d_rvalid stays 0.
- Data write then read: D writes 0xAE08000C to addr 12, then reads addr 12 on the next cycle → d_rvalid exactly once, with d_rdata = 0xAE08000C, 2 cycles after the read accept.
- Contention/starvation with STARVE_LIMIT = 2: i_req and d_req both held high for 6 cycles → grant sequence D, D, I, D, D, I; stall_if is high on exactly the D cycles.
- Interleaved reads: accepts D@3, I@7, D@9 in consecutive cycles → d_rvalid, i_rvalid, d_rvalid on consecutive cycles with data 3, 7, 9.
- Reset mid-flight: assert reset one cycle after a read accept → outputs zero immediately; no rvalid after release; first post-reset request behaves like the single-fetch scenario.
- Idle: no requests for 10 cycles → mem_en = 0, mem_wre = 0, no rvalid, and starve_cnt stays 0 (checked by a following contention run granting D, D, I).
